// File: rtl/difftest_arch_monitor_if.sv
// Commit, register-file and trap bundle from the core under test to the co-simulation monitor.
// The core side drives everything (master); the monitor only observes (slave).
interface difftest_arch_monitor_if #(
    parameter int XLEN = 32
);
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_instr;
    logic            commit_skip;
    logic            commit_wen;
    logic [7:0]      commit_wdest;
    logic [XLEN-1:0] commit_wdata;
    logic [XLEN-1:0] gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7;
    logic [XLEN-1:0] gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15;
    logic [XLEN-1:0] gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23;
    logic [XLEN-1:0] gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31;
    logic            trap_valid;
    logic [2:0]      trap_code;
    logic [63:0]     trap_instr_cnt;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_skip, commit_wen, commit_wdest, commit_wdata,
        output gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7,
        output gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15,
        output gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23,
        output gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31,
        output trap_valid, trap_code, trap_instr_cnt
    );

    modport slave (
        input commit_valid, commit_pc, commit_instr, commit_skip, commit_wen, commit_wdest, commit_wdata,
        input gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7,
        input gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15,
        input gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23,
        input gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31,
        input trap_valid, trap_code, trap_instr_cnt
    );
endinterface

// File: rtl/difftest_arch_monitor.sv
// Shadow-register co-simulation monitor: counters/trap latch 1 cycle, register check 2 cycles after commit.
// No backpressure: every commit is accepted until a trap halts the monitor.
module difftest_arch_monitor #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                coreid,
    difftest_arch_monitor_if.slave    mon,
    output logic [7:0]                core_id_o,
    output logic [63:0]               commit_count,
    output logic [63:0]               cycle_count,
    output logic [XLEN-1:0]           last_pc,
    output logic [31:0]               last_instr,
    output logic                      mismatch,
    output logic [4:0]                mismatch_reg,
    output logic [XLEN-1:0]           mismatch_pc,
    output logic                      halted,
    output logic                      good_trap,
    output logic [2:0]                trap_code_o,
    output logic [63:0]               trap_instr_cnt_o
);

    logic [XLEN-1:0] gpr [NREG];
    assign gpr[0]  = mon.gpr_0;  assign gpr[1]  = mon.gpr_1;  assign gpr[2]  = mon.gpr_2;  assign gpr[3]  = mon.gpr_3;
    assign gpr[4]  = mon.gpr_4;  assign gpr[5]  = mon.gpr_5;  assign gpr[6]  = mon.gpr_6;  assign gpr[7]  = mon.gpr_7;
    assign gpr[8]  = mon.gpr_8;  assign gpr[9]  = mon.gpr_9;  assign gpr[10] = mon.gpr_10; assign gpr[11] = mon.gpr_11;
    assign gpr[12] = mon.gpr_12; assign gpr[13] = mon.gpr_13; assign gpr[14] = mon.gpr_14; assign gpr[15] = mon.gpr_15;
    assign gpr[16] = mon.gpr_16; assign gpr[17] = mon.gpr_17; assign gpr[18] = mon.gpr_18; assign gpr[19] = mon.gpr_19;
    assign gpr[20] = mon.gpr_20; assign gpr[21] = mon.gpr_21; assign gpr[22] = mon.gpr_22; assign gpr[23] = mon.gpr_23;
    assign gpr[24] = mon.gpr_24; assign gpr[25] = mon.gpr_25; assign gpr[26] = mon.gpr_26; assign gpr[27] = mon.gpr_27;
    assign gpr[28] = mon.gpr_28; assign gpr[29] = mon.gpr_29; assign gpr[30] = mon.gpr_30; assign gpr[31] = mon.gpr_31;

    logic [7:0]      core_id_q,        core_id_d;
    logic [63:0]     commit_count_q,   commit_count_d;
    logic [63:0]     cycle_count_q,    cycle_count_d;
    logic [XLEN-1:0] last_pc_q,        last_pc_d;
    logic [31:0]     last_instr_q,     last_instr_d;
    logic            mismatch_q,       mismatch_d;
    logic [4:0]      mismatch_reg_q,   mismatch_reg_d;
    logic [XLEN-1:0] mismatch_pc_q,    mismatch_pc_d;
    logic            halted_q,         halted_d;
    logic            good_trap_q,      good_trap_d;
    logic [2:0]      trap_code_q,      trap_code_d;
    logic [63:0]     trap_instr_cnt_q, trap_instr_cnt_d;
    logic            pending_q,        pending_d;
    logic            pend_skip_q,      pend_skip_d;
    logic [XLEN-1:0] pend_pc_q,        pend_pc_d;
    logic [XLEN-1:0] shadow_q [NREG];
    logic [XLEN-1:0] shadow_d [NREG];

    logic            accept;
    logic [4:0]      wreg;
    logic            diff_found;
    logic [4:0]      diff_reg;
    logic            unused_wdest_hi;

    assign accept          = mon.commit_valid & ~halted_q;
    assign wreg            = mon.commit_wdest[4:0];
    assign unused_wdest_hi = ^mon.commit_wdest[7:5];

    // shadow[0] is never written, so it doubles as the constant-zero reference for gpr_0.
    always_comb begin
        diff_found = 1'b0;
        diff_reg   = 5'd0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (gpr[i] != shadow_q[i]) begin
                diff_found = 1'b1;
                diff_reg   = 5'(i);
            end
        end
    end

    always_comb begin
        core_id_d        = coreid;
        commit_count_d   = commit_count_q;
        cycle_count_d    = cycle_count_q;
        last_pc_d        = last_pc_q;
        last_instr_d     = last_instr_q;
        mismatch_d       = mismatch_q;
        mismatch_reg_d   = mismatch_reg_q;
        mismatch_pc_d    = mismatch_pc_q;
        halted_d         = halted_q;
        good_trap_d      = good_trap_q;
        trap_code_d      = trap_code_q;
        trap_instr_cnt_d = trap_instr_cnt_q;
        pending_d        = accept;
        pend_skip_d      = pend_skip_q;
        pend_pc_d        = pend_pc_q;
        shadow_d         = shadow_q;

        // The check reads the pre-write shadow; a same-cycle commit write lands on top of it.
        if (pending_q) begin
            if (!pend_skip_q) begin
                if (diff_found && !mismatch_q) begin
                    mismatch_d     = 1'b1;
                    mismatch_reg_d = diff_reg;
                    mismatch_pc_d  = pend_pc_q;
                end
            end else begin
                for (int i = 1; i < NREG; i++) begin
                    shadow_d[i] = gpr[i];
                end
            end
        end

        if (accept) begin
            commit_count_d = commit_count_q + 64'd1;
            last_pc_d      = mon.commit_pc;
            last_instr_d   = mon.commit_instr;
            pend_skip_d    = mon.commit_skip;
            pend_pc_d      = mon.commit_pc;
            if (mon.commit_wen && (wreg != 5'd0)) begin
                shadow_d[wreg] = mon.commit_wdata;
            end
        end

        if (!halted_q) begin
            cycle_count_d = cycle_count_q + 64'd1;
        end

        if (mon.trap_valid && !halted_q) begin
            halted_d         = 1'b1;
            trap_code_d      = mon.trap_code;
            good_trap_d      = (mon.trap_code == 3'd0);
            trap_instr_cnt_d = mon.trap_instr_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            core_id_q        <= '0;
            commit_count_q   <= '0;
            cycle_count_q    <= '0;
            last_pc_q        <= '0;
            last_instr_q     <= '0;
            mismatch_q       <= 1'b0;
            mismatch_reg_q   <= '0;
            mismatch_pc_q    <= '0;
            halted_q         <= 1'b0;
            good_trap_q      <= 1'b0;
            trap_code_q      <= '0;
            trap_instr_cnt_q <= '0;
            pending_q        <= 1'b0;
            pend_skip_q      <= 1'b0;
            pend_pc_q        <= '0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            core_id_q        <= core_id_d;
            commit_count_q   <= commit_count_d;
            cycle_count_q    <= cycle_count_d;
            last_pc_q        <= last_pc_d;
            last_instr_q     <= last_instr_d;
            mismatch_q       <= mismatch_d;
            mismatch_reg_q   <= mismatch_reg_d;
            mismatch_pc_q    <= mismatch_pc_d;
            halted_q         <= halted_d;
            good_trap_q      <= good_trap_d;
            trap_code_q      <= trap_code_d;
            trap_instr_cnt_q <= trap_instr_cnt_d;
            pending_q        <= pending_d;
            pend_skip_q      <= pend_skip_d;
            pend_pc_q        <= pend_pc_d;
            shadow_q         <= shadow_d;
        end
    end

    assign core_id_o        = core_id_q;
    assign commit_count     = commit_count_q;
    assign cycle_count      = cycle_count_q;
    assign last_pc          = last_pc_q;
    assign last_instr       = last_instr_q;
    assign mismatch         = mismatch_q;
    assign mismatch_reg     = mismatch_reg_q;
    assign mismatch_pc      = mismatch_pc_q;
    assign halted           = halted_q;
    assign good_trap        = good_trap_q;
    assign trap_code_o      = trap_code_q;
    assign trap_instr_cnt_o = trap_instr_cnt_q;

endmodule

// File: tb/tb_difftest_arch_monitor.sv
// Scoreboard bench: a toy core drives commits and its register file; a reference model predicts outputs.
module tb_difftest_arch_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  coreid;
    logic [7:0]  core_id_o;
    logic [63:0] commit_count, cycle_count, trap_instr_cnt_o;
    logic [31:0] last_pc, last_instr, mismatch_pc;
    logic        mismatch, halted, good_trap;
    logic [4:0]  mismatch_reg;
    logic [2:0]  trap_code_o;

    always #5 clock = ~clock;

    difftest_arch_monitor_if #(.XLEN(32)) bus ();

    difftest_arch_monitor #(.XLEN(32), .NREG(32)) dut (
        .clock(clock), .reset(reset), .coreid(coreid), .mon(bus.slave),
        .core_id_o(core_id_o), .commit_count(commit_count), .cycle_count(cycle_count),
        .last_pc(last_pc), .last_instr(last_instr), .mismatch(mismatch),
        .mismatch_reg(mismatch_reg), .mismatch_pc(mismatch_pc), .halted(halted),
        .good_trap(good_trap), .trap_code_o(trap_code_o), .trap_instr_cnt_o(trap_instr_cnt_o)
    );

    logic [31:0] gpr_drv [32];
    assign bus.gpr_0  = gpr_drv[0];  assign bus.gpr_1  = gpr_drv[1];  assign bus.gpr_2  = gpr_drv[2];  assign bus.gpr_3  = gpr_drv[3];
    assign bus.gpr_4  = gpr_drv[4];  assign bus.gpr_5  = gpr_drv[5];  assign bus.gpr_6  = gpr_drv[6];  assign bus.gpr_7  = gpr_drv[7];
    assign bus.gpr_8  = gpr_drv[8];  assign bus.gpr_9  = gpr_drv[9];  assign bus.gpr_10 = gpr_drv[10]; assign bus.gpr_11 = gpr_drv[11];
    assign bus.gpr_12 = gpr_drv[12]; assign bus.gpr_13 = gpr_drv[13]; assign bus.gpr_14 = gpr_drv[14]; assign bus.gpr_15 = gpr_drv[15];
    assign bus.gpr_16 = gpr_drv[16]; assign bus.gpr_17 = gpr_drv[17]; assign bus.gpr_18 = gpr_drv[18]; assign bus.gpr_19 = gpr_drv[19];
    assign bus.gpr_20 = gpr_drv[20]; assign bus.gpr_21 = gpr_drv[21]; assign bus.gpr_22 = gpr_drv[22]; assign bus.gpr_23 = gpr_drv[23];
    assign bus.gpr_24 = gpr_drv[24]; assign bus.gpr_25 = gpr_drv[25]; assign bus.gpr_26 = gpr_drv[26]; assign bus.gpr_27 = gpr_drv[27];
    assign bus.gpr_28 = gpr_drv[28]; assign bus.gpr_29 = gpr_drv[29]; assign bus.gpr_30 = gpr_drv[30]; assign bus.gpr_31 = gpr_drv[31];

    typedef struct {
        logic [7:0]  core_id;
        logic [63:0] commit_count;
        logic [63:0] cycle_count;
        logic [31:0] last_pc;
        logic [31:0] last_instr;
        logic        mismatch;
        logic [4:0]  mismatch_reg;
        logic [31:0] mismatch_pc;
        logic        halted;
        logic        good_trap;
        logic [2:0]  trap_code;
        logic [63:0] trap_cnt;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    // Toy core: its register file shows a commit's result one cycle after the commit.
    logic [31:0] core_rf [32];
    logic [31:0] skip_val;
    logic        cor_en;
    logic [4:0]  cor_idx;
    logic [31:0] cor_mask;

    // Reference model state: architectural view of what the monitor should report.
    exp_t        m;
    logic [31:0] m_shadow [32];
    logic        m_pending, m_pend_skip;
    logic [31:0] m_pend_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic halted_before;
        int   lo;
        if (reset) begin
            m = '{default: '0};
            for (int i = 0; i < 32; i++) m_shadow[i] = 32'd0;
            m_pending = 1'b0; m_pend_skip = 1'b0; m_pend_pc = 32'd0;
            return;
        end
        halted_before = m.halted;
        m.core_id = coreid;
        if (m_pending) begin
            if (m_pend_skip) begin
                for (int i = 1; i < 32; i++) m_shadow[i] = gpr_drv[i];
            end else begin
                lo = -1;
                for (int i = 0; i < 32 && lo < 0; i++)
                    if (gpr_drv[i] != ((i == 0) ? 32'd0 : m_shadow[i])) lo = i;
                if (lo >= 0 && !m.mismatch) begin
                    m.mismatch = 1'b1; m.mismatch_reg = 5'(lo); m.mismatch_pc = m_pend_pc;
                end
            end
        end
        m_pending = bus.commit_valid && !m.halted;
        if (m_pending) begin
            m.commit_count++;
            m.last_pc = bus.commit_pc; m.last_instr = bus.commit_instr;
            m_pend_skip = bus.commit_skip; m_pend_pc = bus.commit_pc;
            if (bus.commit_wen && bus.commit_wdest[4:0] != 5'd0) m_shadow[bus.commit_wdest[4:0]] = bus.commit_wdata;
        end
        if (bus.trap_valid && !m.halted) begin
            m.halted = 1'b1; m.trap_code = bus.trap_code;
            m.good_trap = (bus.trap_code == 3'd0); m.trap_cnt = bus.trap_instr_cnt;
        end
        if (!halted_before) m.cycle_count++;
    endtask

    task automatic set_idle();
        reset = 1'b0; cor_en = 1'b0;
        bus.commit_valid = 1'b0; bus.commit_skip = 1'b0; bus.commit_wen = 1'b0;
        bus.trap_valid = 1'b0; bus.trap_code = 3'd0; bus.trap_instr_cnt = 64'd0;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic skip, input logic wen,
                              input logic [7:0] wdest, input logic [31:0] wdata);
        bus.commit_valid = 1'b1; bus.commit_pc = pc; bus.commit_instr = $urandom;
        bus.commit_skip = skip; bus.commit_wen = wen; bus.commit_wdest = wdest; bus.commit_wdata = wdata;
    endtask

    // Called at a negedge with the cycle's inputs set; returns at the following negedge.
    task automatic tick();
        for (int i = 0; i < 32; i++) gpr_drv[i] = core_rf[i];
        if (cor_en) gpr_drv[cor_idx] = gpr_drv[cor_idx] ^ cor_mask;
        model_edge();
        exp_q.push_back(m);
        if (reset) begin
            for (int i = 0; i < 32; i++) core_rf[i] = 32'd0;
        end else if (bus.commit_valid && bus.commit_wen && bus.commit_wdest[4:0] != 5'd0) begin
            core_rf[bus.commit_wdest[4:0]] = bus.commit_skip ? skip_val : bus.commit_wdata;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle(); reset = 1'b1; tick(); set_idle();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("core_id_o",        64'(core_id_o),        64'(e.core_id));
                chk("commit_count",     commit_count,          e.commit_count);
                chk("cycle_count",      cycle_count,           e.cycle_count);
                chk("last_pc",          64'(last_pc),          64'(e.last_pc));
                chk("last_instr",       64'(last_instr),       64'(e.last_instr));
                chk("mismatch",         64'(mismatch),         64'(e.mismatch));
                chk("mismatch_reg",     64'(mismatch_reg),     64'(e.mismatch_reg));
                chk("mismatch_pc",      64'(mismatch_pc),      64'(e.mismatch_pc));
                chk("halted",           64'(halted),           64'(e.halted));
                chk("good_trap",        64'(good_trap),        64'(e.good_trap));
                chk("trap_code_o",      64'(trap_code_o),      64'(e.trap_code));
                chk("trap_instr_cnt_o", trap_instr_cnt_o,      e.trap_cnt);
            end
        end
    end

    initial begin
        coreid = 8'h00; skip_val = 32'd0; cor_idx = 5'd0; cor_mask = 32'd0;
        bus.commit_pc = 32'd0; bus.commit_instr = 32'd0; bus.commit_wdest = 8'd0; bus.commit_wdata = 32'd0;
        for (int i = 0; i < 32; i++) begin core_rf[i] = 32'd0; gpr_drv[i] = 32'd0; end
        m = '{default: '0};
        set_idle();
        @(negedge clock);

        // Reset then idle.
        do_reset();
        repeat (10) tick();
        chk("idle cycle_count", cycle_count, 64'd10);
        chk("idle commit_count", commit_count, 64'd0);
        chk("idle mismatch", 64'(mismatch), 64'd0);

        // Matching write-back.
        set_commit(32'h1c000000, 1'b0, 1'b1, 8'd4, 32'hDEADBEEF); tick(); set_idle();
        tick(); tick();
        chk("match commit_count", commit_count, 64'd1);
        chk("match last_pc", 64'(last_pc), 64'h1c000000);
        chk("match mismatch", 64'(mismatch), 64'd0);

        // Divergent write-back: core shows r4 = 0.
        do_reset();
        set_commit(32'h1c000000, 1'b0, 1'b1, 8'd4, 32'hDEADBEEF); tick(); set_idle();
        chk("mm early", 64'(mismatch), 64'd0);
        cor_en = 1'b1; cor_idx = 5'd4; cor_mask = 32'hDEADBEEF; tick(); set_idle();
        chk("mm set", 64'(mismatch), 64'd1);
        chk("mm reg", 64'(mismatch_reg), 64'd4);
        chk("mm pc", 64'(mismatch_pc), 64'h1c000000);
        set_commit(32'h1c000004, 1'b0, 1'b1, 8'd7, 32'h77); tick(); set_idle();
        cor_en = 1'b1; cor_idx = 5'd7; cor_mask = 32'h1; tick(); set_idle();
        tick();
        chk("mm sticky reg", 64'(mismatch_reg), 64'd4);

        // Write to r0 is dropped.
        do_reset();
        set_commit(32'h100, 1'b0, 1'b1, 8'd0, 32'd5); tick(); set_idle();
        tick(); tick();
        chk("r0 mismatch", 64'(mismatch), 64'd0);

        // Skip path resynchronises the shadow.
        do_reset();
        skip_val = 32'h1234;
        set_commit(32'h200, 1'b1, 1'b1, 8'd9, 32'hAAAA); tick(); set_idle();
        set_commit(32'h204, 1'b0, 1'b1, 8'd3, 32'h33); tick(); set_idle();
        tick(); tick();
        chk("skip mismatch", 64'(mismatch), 64'd0);

        // Trap together with a commit, then ignored activity.
        do_reset();
        set_commit(32'h300, 1'b0, 1'b1, 8'd5, 32'h55);
        bus.trap_valid = 1'b1; bus.trap_code = 3'd0; bus.trap_instr_cnt = 64'd42;
        tick(); set_idle();
        chk("trap halted", 64'(halted), 64'd1);
        chk("trap good", 64'(good_trap), 64'd1);
        chk("trap cnt", trap_instr_cnt_o, 64'd42);
        chk("trap commit_count", commit_count, 64'd1);
        for (int i = 0; i < 3; i++) begin
            set_commit(32'h304 + 32'(4 * i), 1'b0, 1'b1, 8'd6, 32'(i)); tick(); set_idle();
        end
        bus.trap_valid = 1'b1; bus.trap_code = 3'd1; bus.trap_instr_cnt = 64'd99; tick(); set_idle();
        tick();
        chk("post-trap commit_count", commit_count, 64'd1);
        chk("second trap code", 64'(trap_code_o), 64'd0);

        // Randomised run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            coreid = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
            end else begin
                if ($urandom_range(0, 99) < 60)
                    set_commit(32'h1c000000 + 32'(4 * c), ($urandom_range(0, 9) == 0),
                               ($urandom_range(0, 9) < 7), 8'($urandom), $urandom);
                skip_val = $urandom;
                if ($urandom_range(0, 39) == 0) begin
                    cor_en = 1'b1; cor_idx = 5'($urandom); cor_mask = $urandom | 32'h1;
                end
                if ($urandom_range(0, 499) == 0) begin
                    bus.trap_valid = 1'b1; bus.trap_code = 3'($urandom); bus.trap_instr_cnt = {$urandom, $urandom};
                end
            end
            tick();
        end
        set_idle();
        tick();
        @(negedge clock);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/difftest_arch_monitor.md
# difftest_arch_monitor

Self-checking co-simulation monitor attached to the CPU's commit and debug ports in the simulation top level. It keeps a 32-entry shadow integer register file built only from committed write-backs. It compares that shadow against the core's reported architectural registers and counts retired instructions. It latches the first divergence and the trap (halt) event, so a testbench or simulation wrapper can stop and report.

## Interface
Parameters:
- XLEN, 32, data, PC and register width.
- NREG, 32, number of architectural integer registers; r0 is hardwired to zero.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- coreid  in  8  core tag; carried to `core_id_o`, no functional effect.
- commit_valid  in  1  an instruction retires this cycle; at most one per cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- commit_instr  in  32  encoding of the retiring instruction.
- commit_skip  in  1  retiring instruction's result must not be checked (MMIO/counter reads).
- commit_wen  in  1  retiring instruction writes a GPR.
- commit_wdest  in  8  destination register; bits [4:0] are used.
- commit_wdata  in  XLEN  value written.
- gpr_0 … gpr_31  in  XLEN each  core's architectural register file as seen this cycle.
- trap_valid  in  1  core signals end of program.
- trap_code  in  3  exit code; 0 means good trap.
- trap_instr_cnt  in  64  core's own retired-instruction count, latched at trap.
- core_id_o  out  8  registered `coreid`.
- commit_count  out  64  instructions accepted by the monitor.
- cycle_count  out  64  cycles since reset; stops when halted.
- last_pc  out  XLEN  PC of the most recent accepted commit.
- last_instr  out  32  encoding of the most recent accepted commit.
- mismatch  out  1  sticky; set on the first register divergence.
- mismatch_reg  out  5  lowest-numbered diverging register.
- mismatch_pc  out  XLEN  PC of the commit whose check failed.
- halted  out  1  sticky; trap seen.
- good_trap  out  1  halted with code 0.
- trap_code_o  out  3  latched exit code.
- trap_instr_cnt_o  out  64  latched core count at trap.

## Operation
- Reset: every output and every internal register clears to 0, including the shadow file, `pending`, `pend_skip` and `pend_pc`.
- Accepted commit: `commit_valid & ~halted`. On an accepted commit:
  - `commit_count` increments by 1.
  - `last_pc` and `last_instr` update.
  - `pending` is set to 1, `pend_skip` ← `commit_skip`, `pend_pc` ← `commit_pc`.
  - If `commit_wen` and wdest[4:0] ≠ 0, shadow[wdest] ← `commit_wdata`. Writes to r0 are dropped.
- Cycles with no accepted commit clear `pending`.
- Check cycle: any cycle where `pending` = 1.
  - If `pend_skip` = 0: compare shadow[i] with gpr_i for i = 1..31. gpr_0 is compared against 0.
  - If any differ and `mismatch` = 0: set `mismatch`, latch the lowest differing i into `mismatch_reg`, and latch `pend_pc` into `mismatch_pc`.
  - If `pend_skip` = 1: no compare. Instead, shadow[1..31] ← gpr_1..gpr_31 (resynchronise).
  - The compare uses the shadow contents before this cycle's own commit write.
  - The shadow write of a same-cycle commit still happens. For wdest = k, the resync loads gpr_k and the new commit write then overrides shadow[k].
- Mismatch: sticky until reset. Later mismatches do not alter the latched values. Commits continue to be counted.
- Trap: when `trap_valid & ~halted`:
  - `halted` ← 1, `trap_code_o` ← `trap_code`, `good_trap` ← (`trap_code` == 0), `trap_instr_cnt_o` ← `trap_instr_cnt`.
  - Later `trap_valid` pulses are ignored.
- Trap and commit in the same cycle: the commit is accepted first, so it is counted and written. All later commits are ignored.
- A check pending when the trap arrives still executes on the next cycle.
- `cycle_count` increments every non-halted cycle.

## Timing
- Counters, `last_*`, shadow writes and trap latches: registered, visible the cycle after the input.
- Register check: the core's gpr_* must reflect commit N one cycle after `commit_valid` for N. `mismatch` rises 2 cycles after the offending commit.
- Back-to-back commits: each gets its own check one cycle later; fully pipelined with no stalls.
- `reset` asserted mid-run clears everything on the next edge, including pending checks.

## Test plan
- Reset then idle 10 cycles, all gpr = 0:
  - all outputs 0 except `cycle_count` = 10;
  - `mismatch` stays 0.
- Commit pc=0x1c000000, wen, wdest=4, wdata=0xDEADBEEF, with gpr_4 = 0xDEADBEEF the next cycle:
  - `commit_count` = 1, `last_pc` = 0x1c000000;
  - no mismatch.
- Same commit, but gpr_4 = 0x0 the next cycle:
  - `mismatch` = 1, `mismatch_reg` = 4, `mismatch_pc` = 0x1c000000, asserted 2 cycles after the commit;
  - a later mismatch on r7 leaves `mismatch_reg` = 4.
- Commit wen, wdest=0, wdata=5: shadow r0 unchanged; gpr_0 = 0 passes.
- Skip path: commit with skip, wdest=9, gpr_9 = 0x1234 next cycle:
  - no mismatch;
  - a following non-skip commit to r3 with gpr_9 held at 0x1234 passes.
- trap_valid, code=0, trap_instr_cnt = 42, together with a commit:
  - `halted` = 1, `good_trap` = 1, `trap_instr_cnt_o` = 42, `commit_count` includes that commit;
  - later commits are ignored;
  - a second trap with code 1 leaves `trap_code_o` = 0.
